// File: rtl/bp_io_host_lite_pkg.sv
// Shared types and default register map for the lite I/O host.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package bp_io_host_lite_pkg;

    typedef enum logic [3:0] {
        e_rd    = 4'd0,
        e_wr    = 4'd1,
        e_uc_rd = 4'd2,
        e_uc_wr = 4'd3
    } bp_msg_type_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_STALL = 2'd1,
        S_RESP  = 2'd2
    } state_e;

    localparam logic [39:0] putchar_addr_gp = 40'h00_0010_1000;
    localparam logic [39:0] finish_addr_gp  = 40'h00_0010_2000;
    localparam logic [39:0] cycle_addr_gp   = 40'h00_0010_3000;

    // Keep only the bytes covered by a log2-byte size; sizes of 8 bytes or more pass through.
    function automatic logic [63:0] size_trunc(input logic [63:0] d, input logic [2:0] size);
        logic [63:0] r;
        case (size)
            3'd0:    r = {56'b0, d[7:0]};
            3'd1:    r = {48'b0, d[15:0]};
            3'd2:    r = {32'b0, d[31:0]};
            default: r = d;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/bp_io_host_lite_fifo.sv
// Small ready-valid FIFO (power-of-two depth) holding putchar bytes.
// Latency: an enqueued entry is visible at the head the cycle after it is written.
// Backpressure: enq_rdy_o drops when full unless the head is popped that same cycle.
module bp_io_host_lite_fifo #(
    parameter int width_p = 8,
    parameter int els_p   = 4
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               enq_v_i,
    input  logic [width_p-1:0] enq_dat_i,
    output logic               enq_rdy_o,
    output logic               deq_v_o,
    output logic [width_p-1:0] deq_dat_o,
    input  logic               deq_rdy_i
);
    localparam int ptr_w = $clog2(els_p);

    logic [width_p-1:0] mem_q [els_p];
    logic [ptr_w:0]     wr_ptr_q, rd_ptr_q;
    logic               empty, full, enq, deq;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty     = (wr_ptr_q == rd_ptr_q);
    assign full      = (wr_ptr_q[ptr_w] != rd_ptr_q[ptr_w]) &&
                       (wr_ptr_q[ptr_w-1:0] == rd_ptr_q[ptr_w-1:0]);
    assign deq_v_o   = ~empty;
    assign deq       = deq_v_o & deq_rdy_i;
    assign enq_rdy_o = ~full | deq;
    assign enq       = enq_v_i & enq_rdy_o;
    // Head is forced to zero when empty so the byte output is clean out of reset.
    assign deq_dat_o = empty ? '0 : mem_q[rd_ptr_q[ptr_w-1:0]];

    // Storage write; contents are don't-care until a pointer covers them.
    always_ff @(posedge clk_i) begin
        if (enq) mem_q[wr_ptr_q[ptr_w-1:0]] <= enq_dat_i;
    end

    // Pointer advance on push and pop.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (enq) wr_ptr_q <= wr_ptr_q + (ptr_w+1)'(1);
            if (deq) rd_ptr_q <= rd_ptr_q + (ptr_w+1)'(1);
        end
    end

endmodule

// File: rtl/bp_io_host_lite.sv
// I/O host for the uncached io_cmd stream: putchar byte FIFO, sticky finish flag, cycle counter.
// Latency: response valid the cycle after accept; longer only while a putchar waits on a full FIFO.
// Backpressure: one command outstanding; io_cmd_ready_o stays low until the response is yumi'd.
module bp_io_host_lite
    import bp_io_host_lite_pkg::*;
#(
    parameter int paddr_width_p   = 40,
    parameter int payload_width_p = 16,
    parameter int tx_fifo_els_p   = 4,
    parameter logic [paddr_width_p-1:0] putchar_addr_p = paddr_width_p'(putchar_addr_gp),
    parameter logic [paddr_width_p-1:0] finish_addr_p  = paddr_width_p'(finish_addr_gp),
    parameter logic [paddr_width_p-1:0] cycle_addr_p   = paddr_width_p'(cycle_addr_gp)
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic [3:0]                 io_cmd_type_i,
    input  logic [paddr_width_p-1:0]   io_cmd_addr_i,
    input  logic [2:0]                 io_cmd_size_i,
    input  logic [63:0]                io_cmd_data_i,
    input  logic [payload_width_p-1:0] io_cmd_payload_i,
    input  logic                       io_cmd_v_i,
    output logic                       io_cmd_ready_o,
    output logic [3:0]                 io_resp_type_o,
    output logic [paddr_width_p-1:0]   io_resp_addr_o,
    output logic [2:0]                 io_resp_size_o,
    output logic [63:0]                io_resp_data_o,
    output logic [payload_width_p-1:0] io_resp_payload_o,
    output logic                       io_resp_v_o,
    input  logic                       io_resp_yumi_i,
    output logic [7:0]                 tx_data_o,
    output logic                       tx_v_o,
    input  logic                       tx_ready_i,
    output logic                       program_finish_o,
    output logic [7:0]                 finish_code_o,
    output logic                       err_unmapped_o
);
    state_e      state_q, state_d;
    logic [63:0] cycle_q;
    logic [7:0]  tx_byte_q;
    logic        accept, cmd_is_wr, hit_put, hit_fin, hit_cyc, put_wr;
    logic        fifo_enq_v, fifo_enq_rdy;
    logic [7:0]  fifo_enq_dat;
    logic [63:0] rd_raw;
    logic        unused_data;

    assign accept    = io_cmd_v_i & io_cmd_ready_o;
    // Only the two write types write; every other type behaves as a read.
    assign cmd_is_wr = (io_cmd_type_i == e_wr) || (io_cmd_type_i == e_uc_wr);
    assign hit_put   = (io_cmd_addr_i == putchar_addr_p);
    assign hit_fin   = (io_cmd_addr_i == finish_addr_p);
    assign hit_cyc   = (io_cmd_addr_i == cycle_addr_p);
    assign put_wr    = cmd_is_wr & hit_put;

    // Push at accept if there is room, otherwise retry from the latched byte while stalled.
    assign fifo_enq_v   = (accept & put_wr) | (state_q == S_STALL);
    assign fifo_enq_dat = (state_q == S_STALL) ? tx_byte_q : io_cmd_data_i[7:0];

    assign io_cmd_ready_o = (state_q == S_IDLE);
    assign io_resp_v_o    = (state_q == S_RESP);
    assign unused_data    = ^io_cmd_data_i[63:8];

    bp_io_host_lite_fifo #(
        .width_p (8),
        .els_p   (tx_fifo_els_p)
    ) tx_fifo (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .enq_v_i   (fifo_enq_v),
        .enq_dat_i (fifo_enq_dat),
        .enq_rdy_o (fifo_enq_rdy),
        .deq_v_o   (tx_v_o),
        .deq_dat_o (tx_data_o),
        .deq_rdy_i (tx_ready_i)
    );

    // Raw read value of the addressed register before size truncation.
    always_comb begin
        rd_raw = '0;
        if (hit_fin)      rd_raw = {63'b0, program_finish_o};
        else if (hit_cyc) rd_raw = cycle_q;
    end

    // FSM state register.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    // Next state: a putchar that finds no FIFO room parks in S_STALL until it can push.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (io_cmd_v_i) state_d = (put_wr && !fifo_enq_rdy) ? S_STALL : S_RESP;
            S_STALL: if (fifo_enq_rdy) state_d = S_RESP;
            S_RESP:  if (io_resp_yumi_i) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Capture the response at accept; read data is sampled here so it stays stable while pending.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            io_resp_type_o    <= '0;
            io_resp_addr_o    <= '0;
            io_resp_size_o    <= '0;
            io_resp_data_o    <= '0;
            io_resp_payload_o <= '0;
            tx_byte_q         <= '0;
        end else if (accept) begin
            io_resp_type_o    <= io_cmd_type_i;
            io_resp_addr_o    <= io_cmd_addr_i;
            io_resp_size_o    <= io_cmd_size_i;
            io_resp_data_o    <= cmd_is_wr ? '0 : size_trunc(rd_raw, io_cmd_size_i);
            io_resp_payload_o <= io_cmd_payload_i;
            tx_byte_q         <= io_cmd_data_i[7:0];
        end
    end

    // Finish flag/code and the sticky unmapped-access flag.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            program_finish_o <= 1'b0;
            finish_code_o    <= '0;
            err_unmapped_o   <= 1'b0;
        end else if (accept) begin
            if (cmd_is_wr && hit_fin) begin
                program_finish_o <= 1'b1;
                finish_code_o    <= io_cmd_data_i[7:0];
            end
            if (!(hit_put || hit_fin || hit_cyc)) err_unmapped_o <= 1'b1;
        end
    end

    // Free-running cycle counter, wraps naturally.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) cycle_q <= '0;
        else         cycle_q <= cycle_q + 64'd1;
    end

endmodule

// File: doc/bp_io_host_lite.md
Name: bp_io_host_lite

Overview:
- Synthesizable I/O host that consumes the BlackParrot softcore uncached I/O command stream (io_cmd) and produces io_resp.
- Sits beside the Wishbone memory bridge, in place of the non-synthesizable simulation host.
- Implements three MMIO registers: putchar (buffered byte stream toward a UART), finish, and a free-running cycle counter.
- Exactly one command is outstanding at a time; each command gets exactly one response.

Parameters:
- paddr_width_p, 40: physical address width.
- payload_width_p, 16: opaque command payload width, echoed unchanged in the response.
- tx_fifo_els_p, 4: putchar FIFO depth; power of two, at least 2.
- putchar_addr_p, 40'h00_0010_1000: putchar register address.
- finish_addr_p, 40'h00_0010_2000: finish register address.
- cycle_addr_p, 40'h00_0010_3000: cycle counter register address (read-only).

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  asynchronous, active-high reset.
- io_cmd_type_i  in  4  message type.
- io_cmd_addr_i  in  paddr_width_p  byte address.
- io_cmd_size_i  in  3  log2 of the size in bytes.
- io_cmd_data_i  in  64  write data.
- io_cmd_payload_i  in  payload_width_p  opaque payload.
- io_cmd_v_i  in  1  command valid.
- io_cmd_ready_o  out  1  ready-valid accept.
- io_resp_type_o, io_resp_addr_o, io_resp_size_o, io_resp_data_o, io_resp_payload_o  out  as matching cmd fields  response fields.
- io_resp_v_o  out  1  response valid.
- io_resp_yumi_i  in  1  response consumed.
- tx_data_o  out  8  putchar byte.
- tx_v_o  out  1  byte valid.
- tx_ready_i  in  1  sink ready.
- program_finish_o  out  1  sticky finish flag.
- finish_code_o  out  8  finish data[7:0].
- err_unmapped_o  out  1  sticky unmapped-access flag.

Behaviour:
- Reset values: every output register is 0, the FIFO is empty, the cycle counter is 0, and the FSM is in S_IDLE. Reset is asynchronous: all state clears immediately, even mid-command or with a response pending.
- Handshake:
  - A command is accepted when io_cmd_v_i & io_cmd_ready_o.
  - io_cmd_ready_o = (state == S_IDLE).
  - The response is held stable while io_resp_v_o=1 and retires when io_resp_yumi_i=1.
  - io_resp_yumi_i must not be asserted while io_resp_v_o=0.
- FSM:
  - S_IDLE -> accept: latch all cmd fields.
  - Putchar write with the FIFO full -> S_STALL. Any other command -> S_RESP.
  - S_STALL -> S_RESP in the first cycle the FIFO is not full; the byte is enqueued in that cycle.
  - S_RESP: io_resp_v_o=1. On yumi -> S_IDLE.
  - Minimum latency: response valid the cycle after accept. Throughput: one command per 2 cycles.
- Response fields: type, addr, size and payload echo the latched command.
  - io_resp_data_o is 0 for writes.
  - For reads it is the register value, truncated to the command size with zeros above.
- Write types are e_uc_wr and e_wr; read types are e_uc_rd and e_rd. Any other type is treated as a read.
- Putchar write: data[7:0] is enqueued in the FIFO.
  - tx_data_o/tx_v_o present the FIFO head; the byte pops on tx_v_o & tx_ready_i.
  - Simultaneous pop and push on a full FIFO is allowed (no stall).
  - Putchar read returns 0.
- Finish write: program_finish_o is set to 1 and finish_code_o = data[7:0]. Later writes update the code; the flag stays set.
  - Finish read returns {63'b0, program_finish_o}.
- Cycle counter:
  - 64-bit, increments every cycle after reset and wraps at 2^64-1 -> 0.
  - A read returns the counter value sampled in the accept cycle.
  - Writes to it are ignored without error.
- Address match is exact on the full paddr, with size ignored. Any other address:
  - reads return 0;
  - writes are dropped;
  - err_unmapped_o is set and stays set (sticky).
  - A response is still issued.

Decomposition:
- Package bp_io_host_lite_pkg holds:
  - msg-type enum (e_rd=0, e_wr=1, e_uc_rd=2, e_uc_wr=3);
  - FSM state enum;
  - default address localparams.
- Sub-module bp_io_host_lite_fifo: the FIFO, with ready-valid on both sides and a simultaneous enq/deq supported when full.

Test Plan:
- After reset, uc_wr to putchar with data 0x41, with tx_ready_i=1 -> response type 3 next cycle, data 0; tx byte 0x41 seen exactly once.
- tx_ready_i=0, 5 putchar writes 0x30..0x34 -> the first 4 respond; the 5th stalls with io_cmd_ready_o=0. Raise tx_ready_i -> bytes drain in order 0x30..0x34 and the 5th response issues.
- uc_wr to finish with data 0x2A -> program_finish_o=1, finish_code_o=0x2A; a subsequent read of finish returns 1.
- Read cycle at size 3 accepted at cycle N after reset -> data equals N (deterministic offset checked). At size 2, the upper 32 bits are 0.
- Read of 0x00_0020_0000 -> data 0, payload echoed, err_unmapped_o=1 and it stays 1 through later valid accesses.
- Hold io_resp_yumi_i=0 for 10 cycles, then assert reset mid-response -> all response fields stable until reset, then all outputs 0 and the FIFO empty asynchronously.
